// File: rtl/rr_select_arb4.sv
// Round-robin arbiter for four requesters feeding a 4:1 mux: registered select,
// one-hot grant, hold-time limit with forced rotation and a one-cycle timeout pulse.
//
// state   | meaning
// IDLE    | no owner; grant=0, select keeps last owner so the mux output stays put
// GRANT   | owner = select; held until done, request drop, or hold limit
module rr_select_arb4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] select,
    output logic [3:0] grant,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic             gv_q, gv_d;
    logic             tout_q, tout_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] owner;
    logic [1:0] next_ptr;
    logic [1:0] win_idle;
    logic [1:0] win_rot;
    logic       hold_hit;
    logic       release_own;

    // First set bit of mask, searching start, start+1, ... modulo 4.
    function automatic logic [1:0] win(input logic [1:0] start, input logic [3:0] mask);
        logic [1:0] result;
        logic [1:0] idx;
        logic       found;
        result = start;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && mask[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign owner       = sel_q;
    assign next_ptr    = owner + 2'd1;
    assign win_idle    = win(ptr_q, req);
    assign win_rot     = win(next_ptr, req);
    assign hold_hit    = HOLD_EN && (cnt_q == HOLD_LAST);
    assign release_own = done | ~req[owner] | hold_hit;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        tout_d  = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = 4'b0000;
                gv_d    = 1'b0;
                if (req != 4'b0000) begin
                    state_d = ST_GRANT;
                    sel_d   = win_idle;
                    grant_d = 4'b0001 << win_idle;
                    gv_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (!release_own) begin
                    // Saturation only matters with no hold limit.
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    ptr_d  = next_ptr;
                    tout_d = hold_hit & ~done & req[owner];
                    cnt_d  = '0;
                    if (req != 4'b0000) begin
                        sel_d   = win_rot;
                        grant_d = 4'b0001 << win_rot;
                        gv_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 4'b0000;
                        gv_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                gv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            gv_q    <= 1'b0;
            tout_q  <= 1'b0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            tout_q  <= tout_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign select    = sel_q;
    assign grant     = grant_q;
    assign gnt_valid = gv_q;
    assign timeout   = tout_q;

endmodule

// File: tb/tb_rr_select_arb4.sv
// Self-checking bench for rr_select_arb4 (MAX_HOLD=4): reference model feeds a
// scoreboard queue at drive time; entries are popped and compared after each edge.
module tb_rr_select_arb4;

    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] select;
    logic [3:0] grant;
    logic       gnt_valid;
    logic       timeout;

    rr_select_arb4 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .select   (select),
        .grant    (grant),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       gv;
        logic       tout;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int m_busy, m_sel, m_ptr, m_cnt, m_tout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int win_m(input int p, input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_tout = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic d);
        int o, w;
        bit hit, rel;
        m_tout = 0;
        if (m_busy == 0) begin
            if (r != 4'b0000) begin
                m_sel  = win_m(m_ptr, r);
                m_busy = 1;
                m_cnt  = 0;
            end
        end else begin
            o   = m_sel;
            hit = (MH != 0) && (m_cnt == MH - 1);
            rel = d || !r[o] || hit;
            if (!rel) begin
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_tout = (hit && !d && r[o]) ? 1 : 0;
                m_ptr  = (o + 1) % 4;
                w      = win_m(m_ptr, r);
                m_cnt  = 0;
                if (w >= 0) m_sel = w;
                else m_busy = 0;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        exp_t e;
        @(negedge clk);
        req  = r;
        done = d;
        model_edge(r, d);
        e.sel  = 2'(m_sel);
        e.gnt  = (m_busy != 0) ? (4'b0001 << m_sel) : 4'b0000;
        e.gv   = (m_busy != 0);
        e.tout = (m_tout != 0);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk_eq("select", 32'(select), 32'(e.sel));
        chk_eq("grant", 32'(grant), 32'(e.gnt));
        chk_eq("gnt_valid", 32'(gnt_valid), 32'(e.gv));
        chk_eq("timeout", 32'(timeout), 32'(e.tout));
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = 4'bxxxx;
        done  = 1'bx;
        #1;
        chk_eq("rst_select", 32'(select), 32'd0);
        chk_eq("rst_grant", 32'(grant), 32'd0);
        chk_eq("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk_eq("rst_timeout", 32'(timeout), 32'd0);
        repeat (3) @(negedge clk);
        req   = 4'b0000;
        done  = 1'b0;
        rst_n = 1'b1;
        model_reset();
        sb_q.delete();
    endtask

    initial begin
        int tp;
        int rot_seq[6];
        rot_seq = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        model_reset();

        // Reset then idle
        do_reset();
        repeat (5) step(4'b0000, 1'b0);

        // Single requester; done coincides with the hold limit -> no timeout
        step(4'b0100, 1'b0);
        chk_eq("single_grant", 32'(grant), 32'h4);
        chk_eq("single_sel", 32'(select), 32'd2);
        repeat (3) step(4'b0100, 1'b0);
        step(4'b0000, 1'b1);
        chk_eq("single_rel_gv", 32'(gnt_valid), 32'd0);
        chk_eq("single_rel_sel", 32'(select), 32'd2);
        chk_eq("single_rel_tout", 32'(timeout), 32'd0);
        repeat (2) step(4'b0000, 1'b0);

        // Full rotation, two cycles per owner, no idle bubble
        do_reset();
        step(4'b1111, 1'b0);
        chk_eq("rot_sel0", 32'(select), 32'(rot_seq[0]));
        for (int i = 1; i < 6; i++) begin
            step(4'b1111, 1'b0);
            chk_eq("rot_gv", 32'(gnt_valid), 32'd1);
            step(4'b1111, 1'b1);
            chk_eq("rot_sel", 32'(select), 32'(rot_seq[i]));
            chk_eq("rot_gv_b2b", 32'(gnt_valid), 32'd1);
        end

        // Timeout rotation between two holders
        do_reset();
        tp = 0;
        for (int k = 0; k < 9; k++) begin
            step(4'b0011, 1'b0);
            tp += int'(timeout);
            if (k == 3) chk_eq("to_ch0_last", 32'(grant), 32'h1);
            if (k == 4) begin
                chk_eq("to_first_grant", 32'(grant), 32'h2);
                chk_eq("to_first_pulse", 32'(timeout), 32'd1);
            end
        end
        chk_eq("to_pulses", 32'(tp), 32'd2);
        chk_eq("to_back_ch0", 32'(grant), 32'h1);

        // Sole requester: re-granted at each timeout, grant never drops
        do_reset();
        tp = 0;
        for (int k = 0; k < 13; k++) begin
            step(4'b1000, 1'b0);
            tp += int'(timeout);
            chk_eq("sole_grant", 32'(grant), 32'h8);
        end
        chk_eq("sole_pulses", 32'(tp), 32'd3);
        chk_eq("sole_sel", 32'(select), 32'd3);

        // Async reset mid-grant, then pointer restarts at 0
        do_reset();
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        chk_eq("mid_grant", 32'(grant), 32'h2);
        do_reset();
        step(4'b0110, 1'b0);
        chk_eq("post_rst_grant", 32'(grant), 32'h2);
        chk_eq("post_rst_sel", 32'(select), 32'd1);
        repeat (3) step(4'b0110, 1'b0);
        step(4'b0110, 1'b1);
        chk_eq("post_rst_next", 32'(grant), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
